// File: rtl/reg_write_demux.sv
// reg_write_demux
//   Sixteen 16-bit registers behind a valid/ready write port, with a
//   4-to-16 one-hot write decode and full-word, low-byte and high-byte
//   write modes. A clear request starts a sweep that zeroes one register
//   per cycle, from index 0 to index 15, while the write port is held off.
//
// Ports
//   clk        : clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   wr_valid   : write request present
//   wr_ready   : write port can accept this cycle (IDLE only)
//   wr_addr    : destination register index 0..15
//   wr_mode    : 00 word, 01 low byte, 10 high byte, 11 no-op
//   wr_data    : write data (byte modes use wr_data[7:0])
//   clr_req    : one-cycle pulse starting a clear sweep
//   busy       : clear sweep in progress
//   wr_strobe  : one-hot of the register written on the previous edge
//   regs_flat  : register k on bits [16k+15:16k]
//
// Configuration
//   REG0_ZERO_EN : when defined, register 0 is hard-wired to zero; writes
//                  to address 0 complete the handshake but store nothing.

module reg_write_demux (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [3:0]   wr_addr,
  input  logic [1:0]   wr_mode,
  input  logic [15:0]  wr_data,
  input  logic         clr_req,
  output logic         busy,
  output logic [15:0]  wr_strobe,
  output logic [255:0] regs_flat
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_sweepCnt;
  logic        r_ready;
  logic        r_busy;
  logic [15:0] r_strobe;
  logic [15:0] r_regs [16];

  logic        w_fire;
  logic [15:0] w_addrOneHot;
  logic [15:0] w_wrEn;

  // r_ready is only ever high in IDLE, so a fired write implies IDLE.
  assign w_fire       = wr_valid & r_ready;
  assign w_addrOneHot = 16'h0001 << wr_addr;

  // Per-register write enable; the no-op mode fires the handshake only.
  always_comb begin
    w_wrEn = '0;
    if (w_fire && (wr_mode != 2'b11)) begin
      w_wrEn = w_addrOneHot;
    end
`ifdef REG0_ZERO_EN
    w_wrEn[0] = 1'b0;
`endif
  end

  // Byte modes always source the byte from wr_data[7:0].
  function automatic logic [15:0] mergeWrite(input logic [15:0] oldVal,
                                             input logic [1:0]  mode,
                                             input logic [15:0] data);
    logic [15:0] newVal;
    newVal = oldVal;
    case (mode)
      2'b00:   newVal = data;
      2'b01:   newVal = {oldVal[15:8], data[7:0]};
      2'b10:   newVal = {data[7:0], oldVal[7:0]};
      default: newVal = oldVal;
    endcase
    return newVal;
  endfunction

  // Single FSM block. A write and a clear request in the same IDLE cycle
  // both take effect on one edge: the write lands and CLEAR starts, so the
  // sweep begins on the following edge. wr_ready comes up on the first
  // edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sweepCnt <= 4'd0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_strobe   <= '0;
      for (int k = 0; k < 16; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      r_strobe <= '0;
      case (r_state)
        IDLE: begin
          for (int k = 0; k < 16; k++) begin
            if (w_wrEn[k]) begin
              r_regs[k] <= mergeWrite(r_regs[k], wr_mode, wr_data);
            end
          end
          r_strobe <= w_wrEn;
          if (clr_req) begin
            r_state    <= CLEAR;
            r_sweepCnt <= 4'd0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        CLEAR: begin
          // clr_req is ignored here; the sweep never restarts.
          r_regs[r_sweepCnt] <= '0;
          r_sweepCnt         <= r_sweepCnt + 4'd1;
          if (r_sweepCnt == 4'd15) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready  = r_ready;
  assign busy      = r_busy;
  assign wr_strobe = r_strobe;

  // Flatten the register file for an external 16:1 read select.
  genvar g;
  for (g = 0; g < 16; g++) begin : gFlat
    if (g == 0) begin : gReg0
`ifdef REG0_ZERO_EN
      assign regs_flat[15:0] = 16'h0000;
`else
      assign regs_flat[15:0] = r_regs[0];
`endif
    end else begin : gRegN
      assign regs_flat[16*g +: 16] = r_regs[g];
    end
  end

endmodule
